fetch_dispatch: RTL and testbench
=================================

# fetch_dispatch

Instruction fetch and dispatch stage, directly upstream of the per-opcode execution FSMs (MOVI and siblings). Holds the program counter, reads 16-bit instructions from a synchronous instruction memory, and presents each one on the shared instruction bus that every execution FSM decodes. It clears that bus between instructions so every FSM returns to its idle state. It advances on the FSMs' `PC_inc` and `done` strobes and stops on HALT.

## Interface
- `PC_W`, 8: program counter / instruction address width.
- `WDOG_CYCLES`, 64: watchdog limit in cycles. Used only when `FETCH_WDOG_EN` is defined.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  PC_W  instruction memory address; equals `pc`.
- `imem_data`  in  16  instruction memory read data; valid one cycle after the address is presented.
- `fullBitNum`  out  16  instruction bus to the execution FSMs; bits [15:12] opcode, [11:6] param1, [5:0] param2.
- `PC_inc`  in  1  OR of all execution FSMs' PC_inc.
- `done`  in  1  OR of all execution FSMs' done.
- `pc_load`  in  1  branch request from a jump FSM.
- `pc_load_val`  in  PC_W  branch target.
- `pc`  out  PC_W  current program counter.
- `busy`  out  1  high in every state except HALT and TRAP.
- `halted`  out  1  high in HALT.
- `trap`  out  1  high in TRAP; constant 0 without `FETCH_WDOG_EN`.

## Operation
- States: FETCH, LOAD, EXEC, HALT, TRAP.
- Reset (rst low): state FETCH, `pc`=0, `fullBitNum`=16'h0000, `busy`=1, `halted`=0, `trap`=0, watchdog counter=0. Reset mid-instruction aborts it immediately.
- FETCH: `fullBitNum`=0 (NOP opcode; no FSM matches, so all FSMs reset to st0). Next state LOAD.
- LOAD: capture `imem_data` into the IR at the clock edge. Next-state decode on `imem_data[15:12]`:
  - 4'h0 (NOP): `pc`+1, go to FETCH.
  - 4'hF (HALT): go to HALT.
  - Otherwise: go to EXEC.
- EXEC: `fullBitNum`=IR.
  - `pc_load`=1: `pc` takes `pc_load_val`.
  - Else if `PC_inc`=1: `pc`+1.
  - `pc_load` has priority when both are high.
  - On the first cycle with `done`=1, go to FETCH. A second `done` cycle arrives during FETCH and is ignored.
- `PC_inc` and `pc_load` are ignored outside EXEC.
- HALT: `fullBitNum`=0 and `pc` frozen. Held until reset.
- PC arithmetic is modulo 2^PC_W: 2^PC_W−1 increments to 0.

## Timing
- Instruction turnaround: FETCH (1 cycle) + LOAD (1 cycle) + EXEC (FSM-dependent).
- MOVI:
  - IR visible in EXEC cycle 0.
  - `PC_inc` in cycle 1, first `done` in cycle 3.
  - Back to FETCH in cycle 4, so 6 cycles per MOVI.
- NOP: 2 cycles (FETCH, LOAD).
- `fullBitNum` is registered. No combinational path from `done`/`PC_inc` to `fullBitNum`.
- `imem_addr` is combinational from `pc`, so an increment in EXEC is visible at the next FETCH.

## Configuration
- `FETCH_WDOG_EN` defined:
  - Counter clears on EXEC entry and increments each EXEC cycle without `done`.
  - When the count reaches `WDOG_CYCLES`, go to TRAP, clear `fullBitNum`, and assert `trap` until reset.
  - `done` in the same cycle the limit is reached takes priority, so the state goes to FETCH.
- Not defined: no counter, EXEC waits indefinitely, `trap` tied 0, TRAP unreachable.

## Structure
- Shared package:
  - Opcode constants: OP_NOP=4'h0, OP_MOVI=4'h7, OP_HALT=4'hF.
  - State encoding constants (3-bit).
  - Instruction field bit positions.
- One sub-module, `pc_reg`: PC register with load/increment priority and async active-low reset. All other logic inline.

## Test plan
- Reset, memory [0]=16'h7085 (MOVI G1,#5), [1]=16'hF000:
  - `fullBitNum`=16'h7085 for 4 cycles starting cycle 2.
  - `pc` goes 0→1 on `PC_inc`.
  - Then HALT: `halted`=1, `pc`=1, `fullBitNum`=0.
- Memory [0..2]=16'h0000, [3]=16'hF000: `pc` steps 0,1,2,3 at 2-cycle intervals, then `halted`=1.
- EXEC with `pc`=5:
  - `PC_inc` and `pc_load`(val=8'h20) high in the same cycle → `pc`=8'h20.
  - `pc`=8'hFF with `PC_inc` → `pc`=0.
- rst low in EXEC cycle 2 of MOVI → asynchronously `pc`=0, `fullBitNum`=0. Fetch restarts at address 0 after release.
- With `FETCH_WDOG_EN`, `WDOG_CYCLES`=8, opcode 4'h3 with no responding FSM → `trap`=1 after 8 EXEC cycles, `busy`=0. Without the macro, `busy` stays 1 indefinitely.
- `done` held 2 cycles → exactly one FETCH, with no skipped instruction and no double `pc` increment.

Source files
------------

// File: rtl/fetch_dispatch_pkg.sv
// Shared opcode, FSM state and instruction-field definitions for the fetch/dispatch stage.
package fetch_dispatch_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned P1_W    = 6;
    localparam int unsigned P2_W    = 6;

    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned P1_LSB  = 6;
    localparam int unsigned P2_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_MOVI = 4'h7;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_TRAP  = 3'd4
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [P1_W-1:0]  param1;
        logic [P2_W-1:0]  param2;
    } instr_t;

    // Split a raw memory word into its instruction fields.
    function automatic instr_t instr_unpack(input logic [INSTR_W-1:0] word);
        instr_t ins;
        ins.opcode = word[OPC_LSB +: OPC_W];
        ins.param1 = word[P1_LSB +: P1_W];
        ins.param2 = word[P2_LSB +: P2_W];
        return ins;
    endfunction

endpackage

// File: rtl/fetch_dispatch_pc_reg.sv
// Program counter register: branch load wins over increment, wraps modulo 2^PC_W.
module pc_reg #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end else if (inc_en) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_dispatch.sv
// Instruction fetch/dispatch stage: drives the shared instruction bus for the execution FSMs.
// Optional EXEC watchdog enabled by defining FETCH_WDOG_EN.
module fetch_dispatch
    import fetch_dispatch_pkg::*;
#(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] fullBitNum,
    input  logic               PC_inc,
    input  logic               done,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_load_val,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               trap
);

    state_e               state_q;
    state_e               state_d;
    instr_t               ir_q;
    instr_t               ir_d;
    instr_t               ld_instr_c;
    logic [INSTR_W-1:0]   fbn_q;
    logic [INSTR_W-1:0]   fbn_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 halted_q;
    logic                 halted_d;
    logic                 trap_q;
    logic                 trap_d;
    logic                 pc_ld_c;
    logic                 pc_inc_c;
    logic                 wdog_hit_c;

    assign ld_instr_c = instr_unpack(imem_data);

`ifdef FETCH_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;

    // Limit is hit when this EXEC cycle would be the WDOG_CYCLES-th without done.
    assign wdog_hit_c = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_d = wdog_q;
        if ((state_q != ST_EXEC) && (state_d == ST_EXEC)) begin
            wdog_d = '0;
        end else if ((state_q == ST_EXEC) && !done) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog;

    assign wdog_hit_c  = 1'b0;
    assign unused_wdog = (WDOG_CYCLES == 0);
`endif

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            fbn_q    <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            fbn_q    <= fbn_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    // Next-state decode; done wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (ld_instr_c.opcode == OP_NOP) begin
                    state_d = ST_FETCH;
                end else if (ld_instr_c.opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (done) begin
                    state_d = ST_FETCH;
                end else if (wdog_hit_c) begin
                    state_d = ST_TRAP;
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs are computed from the next state so the bus is valid in the first EXEC cycle.
    always_comb begin
        ir_d     = ir_q;
        fbn_d    = '0;
        busy_d   = 1'b1;
        halted_d = 1'b0;
        trap_d   = 1'b0;
        pc_ld_c  = 1'b0;
        pc_inc_c = 1'b0;

        if (state_q == ST_LOAD) begin
            ir_d     = ld_instr_c;
            pc_inc_c = (ld_instr_c.opcode == OP_NOP);
        end

        if (state_q == ST_EXEC) begin
            pc_ld_c  = pc_load;
            pc_inc_c = PC_inc;
        end

        case (state_d)
            ST_EXEC: fbn_d = ir_d;
            ST_HALT: begin
                busy_d   = 1'b0;
                halted_d = 1'b1;
            end
            ST_TRAP: begin
                busy_d = 1'b0;
                trap_d = 1'b1;
            end
            default: fbn_d = '0;
        endcase
    end

    pc_reg #(
        .PC_W(PC_W)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst),
        .load_en  (pc_ld_c),
        .load_val (pc_load_val),
        .inc_en   (pc_inc_c),
        .pc       (pc)
    );

    assign imem_addr  = pc;
    assign fullBitNum = fbn_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_fetch_dispatch.sv
// Scoreboard bench for fetch_dispatch: directed programs, per-cycle expected snapshots.
module tb_fetch_dispatch;

    localparam int unsigned PC_W = 8;
    localparam int unsigned WDOG = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [15:0]     fullBitNum;
    logic            PC_inc;
    logic            done;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_val;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;
    logic            trap;

    logic [15:0] mem [256];

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [7:0]  pc;
        logic [15:0] fbn;
        logic        busy;
        logic        halted;
        logic        trap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fetch_dispatch #(
        .PC_W        (PC_W),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .fullBitNum  (fullBitNum),
        .PC_inc      (PC_inc),
        .done        (done),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare against the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || pc !== mon_e.pc || imem_addr !== mon_e.pc ||
                fullBitNum !== mon_e.fbn || busy !== mon_e.busy ||
                halted !== mon_e.halted || trap !== mon_e.trap) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d: got pc=%h addr=%h fbn=%h busy=%b halted=%b trap=%b, want pc=%h fbn=%h busy=%b halted=%b trap=%b",
                         mon_e.name, cyc, mon_e.cyc, pc, imem_addr, fullBitNum, busy, halted, trap,
                         mon_e.pc, mon_e.fbn, mon_e.busy, mon_e.halted, mon_e.trap);
            end
        end
    end

    task automatic expect_at(input int n, input string nm, input logic [7:0] p,
                             input logic [15:0] f, input logic b, input logic h, input logic t);
        exp_t e;
        e.cyc    = base + n;
        e.name   = nm;
        e.pc     = p;
        e.fbn    = f;
        e.busy   = b;
        e.halted = h;
        e.trap   = t;
        sb.push_back(e);
    endtask

    // Drive inputs for the current cycle, then advance one cycle.
    task automatic tick(input logic inc, input logic dn, input logic ld, input logic [7:0] val);
        PC_inc      = inc;
        done        = dn;
        pc_load     = ld;
        pc_load_val = val;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    // Hold reset one cycle (checking the reset state), release mid-cycle; base = FETCH cycle 0.
    task automatic do_reset();
        PC_inc      = 1'b0;
        done        = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        rst         = 1'b0;
        @(posedge clk);
        #1;
        base = cyc;
        expect_at(0, "reset_state", 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst  = 1'b1;
        base = cyc;
    endtask

    task automatic drain();
        int k;
        PC_inc  = 1'b0;
        done    = 1'b0;
        pc_load = 1'b0;
        k = 0;
        while (sb.size() > 0 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    initial begin
        rst = 1'b0;
        PC_inc = 1'b0; done = 1'b0; pc_load = 1'b0; pc_load_val = '0;

        // MOVI then HALT
        clear_mem();
        mem[0] = 16'h7085;
        mem[1] = 16'hF000;
        do_reset();
        expect_at(1,  "t1_load",      8'h00, 16'h0000, 1, 0, 0);
        expect_at(2,  "t1_exec0",     8'h00, 16'h7085, 1, 0, 0);
        expect_at(3,  "t1_exec1",     8'h00, 16'h7085, 1, 0, 0);
        expect_at(4,  "t1_exec2_inc", 8'h01, 16'h7085, 1, 0, 0);
        expect_at(5,  "t1_exec3",     8'h01, 16'h7085, 1, 0, 0);
        expect_at(6,  "t1_fetch",     8'h01, 16'h0000, 1, 0, 0);
        expect_at(7,  "t1_load_halt", 8'h01, 16'h0000, 1, 0, 0);
        expect_at(8,  "t1_halt",      8'h01, 16'h0000, 0, 1, 0);
        expect_at(12, "t1_halt_hold", 8'h01, 16'h0000, 0, 1, 0);
        idle(3);
        tick(1, 0, 0, 8'h00);
        idle(1);
        tick(0, 1, 0, 8'h00);
        tick(0, 1, 0, 8'h00);
        idle(2);
        tick(1, 1, 1, 8'h33);
        tick(1, 1, 1, 8'h33);
        idle(3);
        drain();

        // NOP stream then HALT
        clear_mem();
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'hF000;
        do_reset();
        expect_at(1, "t2_load0",  8'h00, 16'h0000, 1, 0, 0);
        expect_at(2, "t2_pc1",    8'h01, 16'h0000, 1, 0, 0);
        expect_at(3, "t2_load1",  8'h01, 16'h0000, 1, 0, 0);
        expect_at(4, "t2_pc2",    8'h02, 16'h0000, 1, 0, 0);
        expect_at(6, "t2_pc3",    8'h03, 16'h0000, 1, 0, 0);
        expect_at(8, "t2_halt",   8'h03, 16'h0000, 0, 1, 0);
        idle(12);
        drain();

        // Branch priority, wrap, and strobes ignored outside EXEC
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 16'h0000;
        mem[5]     = 16'h7000;
        mem[8'h20] = 16'h7001;
        do_reset();
        expect_at(10, "t3_fetch_pc5",   8'h05, 16'h0000, 1, 0, 0);
        expect_at(12, "t3_exec_pc5",    8'h05, 16'h7000, 1, 0, 0);
        expect_at(13, "t3_load_wins",   8'h20, 16'h7000, 1, 0, 0);
        expect_at(14, "t3_fetch_20",    8'h20, 16'h0000, 1, 0, 0);
        expect_at(15, "t3_inc_ign",     8'h20, 16'h0000, 1, 0, 0);
        expect_at(16, "t3_ld_ign",      8'h20, 16'h7001, 1, 0, 0);
        expect_at(17, "t3_pc_ff",       8'hFF, 16'h7001, 1, 0, 0);
        expect_at(18, "t3_wrap",        8'h00, 16'h7001, 1, 0, 0);
        expect_at(19, "t3_fetch0",      8'h00, 16'h0000, 1, 0, 0);
        expect_at(21, "t3_ld_ign_nop",  8'h01, 16'h0000, 1, 0, 0);
        idle(12);
        tick(1, 0, 1, 8'h20);
        tick(0, 1, 0, 8'h00);
        tick(1, 0, 0, 8'h00);
        tick(1, 0, 1, 8'h44);
        tick(0, 0, 1, 8'hFF);
        tick(1, 0, 0, 8'h00);
        tick(0, 1, 0, 8'h00);
        tick(0, 0, 1, 8'h55);
        tick(0, 0, 1, 8'h55);
        idle(4);
        drain();

        // Asynchronous reset in EXEC cycle 2, then restart from address 0
        clear_mem();
        mem[0] = 16'h7085;
        mem[1] = 16'hF000;
        do_reset();
        expect_at(2, "t4_exec0", 8'h00, 16'h7085, 1, 0, 0);
        expect_at(3, "t4_exec1", 8'h00, 16'h7085, 1, 0, 0);
        idle(3);
        tick(1, 0, 0, 8'h00);
        expect_at(4, "t4_async_rst", 8'h00, 16'h0000, 1, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst  = 1'b1;
        base = cyc;
        expect_at(1, "t4_reload",  8'h00, 16'h0000, 1, 0, 0);
        expect_at(2, "t4_reexec",  8'h00, 16'h7085, 1, 0, 0);
        expect_at(4, "t4_reinc",   8'h01, 16'h7085, 1, 0, 0);
        expect_at(8, "t4_rehalt",  8'h01, 16'h0000, 0, 1, 0);
        idle(3);
        tick(1, 0, 0, 8'h00);
        idle(1);
        tick(0, 1, 0, 8'h00);
        idle(5);
        drain();

`ifdef FETCH_WDOG_EN
        // Unanswered opcode traps after WDOG EXEC cycles
        clear_mem();
        mem[0] = 16'h3000;
        do_reset();
        expect_at(2,  "t5_exec0",      8'h00, 16'h3000, 1, 0, 0);
        expect_at(9,  "t5_exec_last",  8'h00, 16'h3000, 1, 0, 0);
        expect_at(10, "t5_trap",       8'h00, 16'h0000, 0, 0, 1);
        expect_at(14, "t5_trap_hold",  8'h00, 16'h0000, 0, 0, 1);
        idle(16);
        drain();

        // done at the limit wins; counter restarts on the next EXEC entry
        clear_mem();
        mem[0] = 16'h3000;
        do_reset();
        expect_at(9,  "t5b_exec_last", 8'h00, 16'h3000, 1, 0, 0);
        expect_at(10, "t5b_done_wins", 8'h00, 16'h0000, 1, 0, 0);
        expect_at(12, "t5b_reexec",    8'h00, 16'h3000, 1, 0, 0);
        expect_at(19, "t5b_last2",     8'h00, 16'h3000, 1, 0, 0);
        expect_at(20, "t5b_trap2",     8'h00, 16'h0000, 0, 0, 1);
        idle(9);
        tick(0, 1, 0, 8'h00);
        idle(14);
        drain();
`else
        // Without the watchdog EXEC waits indefinitely
        clear_mem();
        mem[0] = 16'h3000;
        do_reset();
        expect_at(2,  "t5_exec0",   8'h00, 16'h3000, 1, 0, 0);
        expect_at(10, "t5_exec10",  8'h00, 16'h3000, 1, 0, 0);
        expect_at(40, "t5_exec40",  8'h00, 16'h3000, 1, 0, 0);
        expect_at(72, "t5_exec72",  8'h00, 16'h3000, 1, 0, 0);
        expect_at(73, "t5_fetch",   8'h00, 16'h0000, 1, 0, 0);
        idle(72);
        tick(0, 1, 0, 8'h00);
        idle(3);
        drain();
`endif

        // done held two cycles with PC_inc during FETCH: one FETCH, one increment
        clear_mem();
        mem[0] = 16'h7085;
        mem[1] = 16'h7086;
        mem[2] = 16'hF000;
        do_reset();
        expect_at(5,  "t6_exec3",     8'h01, 16'h7085, 1, 0, 0);
        expect_at(6,  "t6_fetch",     8'h01, 16'h0000, 1, 0, 0);
        expect_at(7,  "t6_no_dblinc", 8'h01, 16'h0000, 1, 0, 0);
        expect_at(8,  "t6_next_ins",  8'h01, 16'h7086, 1, 0, 0);
        expect_at(10, "t6_inc2",      8'h02, 16'h7086, 1, 0, 0);
        expect_at(12, "t6_fetch2",    8'h02, 16'h0000, 1, 0, 0);
        expect_at(14, "t6_halt",      8'h02, 16'h0000, 0, 1, 0);
        idle(3);
        tick(1, 0, 0, 8'h00);
        idle(1);
        tick(0, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        idle(2);
        tick(1, 0, 0, 8'h00);
        idle(1);
        tick(0, 1, 0, 8'h00);
        tick(0, 1, 0, 8'h00);
        idle(4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
